io_slave_regfile: RTL and testbench



---
 rtl/io_pkg.sv | 32 +++
 rtl/io_irq_ctrl.sv | 53 +++++
 rtl/io_slave_regfile.sv | 214 +++++++++++++++++++++
 tb/tb_io_slave_regfile.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the io_slave_regfile register responder.
//   - state_e      : handshake state (IDLE, WAIT, ACK)
//   - NREG_MAX     : largest supported register bank
//   - lane_mask()  : expands a 4-bit byte-lane select into a 32-bit mask
//   - byte_merge() : merges new data into an old word under byte-lane selects
package io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int NREG_MAX = 64;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) begin
            m[k*8 +: 8] = {8{sel[k]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = lane_mask(sel);
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: interrupt pending/enable logic for io_slave_regfile.
// Only instantiated when IO_SLAVE_IRQ_EN is defined.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   src_i[31:0]       interrupt sources (rising edge sets pending)
//   en_i[31:0]        interrupt enable register contents
//   clr_i             write-1-to-clear strobe for the pending register
//   clr_mask_i[31:0]  bits to clear (write data already masked by byte lanes)
//   pend_o[31:0]      pending register
//   irq_o             registered OR of pending & enable
module io_irq_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] src_i,
    input  logic [31:0] en_i,
    input  logic        clr_i,
    input  logic [31:0] clr_mask_i,
    output logic [31:0] pend_o,
    output logic        irq_o
);

    logic [31:0] src_q;
    logic [31:0] pend_q, pend_d;
    logic        irq_q;
    logic [31:0] rise;

    assign rise = src_i & ~src_q;

    // Set is OR-ed in after the clear so a simultaneous edge keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = pend_d & ~clr_mask_i;
        end
        pend_d = pend_d | rise;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src_q  <= '0;
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            src_q  <= src_i;
            pend_q <= pend_d;
            irq_q  <= |(pend_q & en_i);
        end
    end

    assign pend_o = pend_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/io_slave_regfile.sv
// io_slave_regfile: device-side responder for the I/O bridge master port.
// Serves NREG 32-bit registers with byte-lane writes, WAIT_STATES extra
// cycles before ack, and ack held until the strobe drops.
// Optional feature macro: IO_SLAVE_IRQ_EN (reg NREG-2 = irq enable,
// reg NREG-1 = W1C irq pending, irq_o driven). Without it irq_o = 0.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   cs_i, cyc_i, stb_i  chip select, bus cycle, strobe
//   we_i, sel_i, adr_i  write enable, byte lanes, address ([IDX+1:2] used)
//   dat_i / dat_o       write data / read data (0 when ack_o is low)
//   ack_o, stall_o      acknowledge, busy
//   reg_o               register contents, reg n at [n*32 +: 32]
//   reg_i               read-only sources for regs flagged in RO_MASK
//   wr_pulse_o          one-cycle pulse per committed write to reg n
//   irq_src_i, irq_o    interrupt sources / request
module io_slave_regfile
    import io_pkg::*;
#(
    parameter int              NREG        = 16,
    parameter int              WAIT_STATES = 1,
    parameter logic [NREG-1:0] RO_MASK     = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cs_i,
    input  logic               cyc_i,
    input  logic               stb_i,
    output logic               ack_o,
    output logic               stall_o,
    input  logic               we_i,
    input  logic [3:0]         sel_i,
    input  logic [31:0]        adr_i,
    input  logic [31:0]        dat_i,
    output logic [31:0]        dat_o,
    output logic [NREG*32-1:0] reg_o,
    input  logic [NREG*32-1:0] reg_i,
    output logic [NREG-1:0]    wr_pulse_o,
    input  logic [31:0]        irq_src_i,
    output logic               irq_o
);

    localparam int IDX_W = $clog2(NREG);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

`ifdef IO_SLAVE_IRQ_EN
    localparam logic [NREG-1:0] EN_BIT   = {2'b01, {(NREG-2){1'b0}}};
    localparam logic [NREG-1:0] PEND_BIT = {2'b10, {(NREG-2){1'b0}}};
    // The irq registers are always writable; pending lives in io_irq_ctrl.
    localparam logic [NREG-1:0] RO_EFF   = RO_MASK & ~(EN_BIT | PEND_BIT);
    localparam logic [NREG-1:0] STORE    = ~RO_EFF & ~PEND_BIT;
`else
    localparam logic [NREG-1:0] RO_EFF   = RO_MASK;
    localparam logic [NREG-1:0] STORE    = ~RO_EFF;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             we_q;
    logic [3:0]       sel_q;
    logic [31:0]      wdat_q;
    logic [31:0]      rdata_q;
    logic [NREG-1:0]  wr_pulse_q;
    logic [31:0]      regs_q [NREG];
    logic [31:0]      rview  [NREG];

    logic             accept;
    logic             commit;
    logic             reg_wr;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_we;
    logic [3:0]       cur_sel;
    logic [31:0]      cur_dat;

    logic unused_bits;
    assign unused_bits = ^{adr_i[31:IDX_W+2], adr_i[1:0]};

    assign accept = (state_q == IDLE) && cs_i && cyc_i && stb_i;

    // With no wait states the commit happens on the accept edge itself,
    // so the live bus fields are used while still in IDLE.
    assign cur_idx = (state_q == IDLE) ? adr_i[IDX_W+1:2] : idx_q;
    assign cur_we  = (state_q == IDLE) ? we_i  : we_q;
    assign cur_sel = (state_q == IDLE) ? sel_i : sel_q;
    assign cur_dat = (state_q == IDLE) ? dat_i : wdat_q;

    assign commit = (state_d == ACK) && (state_q != ACK);
    assign reg_wr = commit && cur_we && STORE[cur_idx];

    // State register and request latch
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            wdat_q     <= '0;
            rdata_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pulse_q <= '0;
            if (accept) begin
                idx_q  <= adr_i[IDX_W+1:2];
                we_q   <= we_i;
                sel_q  <= sel_i;
                wdat_q <= dat_i;
            end
            if (commit) begin
                rdata_q <= rview[cur_idx];
                if (cur_we) begin
                    wr_pulse_q[cur_idx] <= 1'b1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                // A dropped cycle aborts even on the final wait cycle.
                if (!cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                if (!stb_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ack_o   = (state_q == ACK);
        stall_o = (state_q != IDLE);
        dat_o   = '0;
        if (state_q == ACK) begin
            dat_o = rdata_q;
        end
    end

    // Register bank
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= '0;
            end
        end else if (reg_wr) begin
            regs_q[cur_idx] <= byte_merge(regs_q[cur_idx], cur_dat, cur_sel);
        end
    end

`ifdef IO_SLAVE_IRQ_EN
    logic [31:0] pend;
    logic        pend_clr;

    assign pend_clr = commit && cur_we && (cur_idx == IDX_W'(NREG - 1));

    io_irq_ctrl u_irq (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .src_i      (irq_src_i),
        .en_i       (regs_q[NREG-2]),
        .clr_i      (pend_clr),
        .clr_mask_i (cur_dat & lane_mask(cur_sel)),
        .pend_o     (pend),
        .irq_o      (irq_o)
    );
`else
    logic unused_irq;
    assign unused_irq = ^irq_src_i;
    assign irq_o      = 1'b0;
`endif

    // Visible register contents: read-only slots mirror reg_i.
    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            rview[n] = RO_EFF[n] ? reg_i[n*32 +: 32] : regs_q[n];
        end
`ifdef IO_SLAVE_IRQ_EN
        rview[NREG-1] = pend;
`endif
    end

    for (genvar g = 0; g < NREG; g++) begin : g_rego
        assign reg_o[g*32 +: 32] = rview[g];
    end

    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_io_slave_regfile.sv
module tb_io_slave_regfile;

    localparam int NREG = 16;
    localparam int NI   = 3;
`ifdef IO_SLAVE_IRQ_EN
    localparam bit IRQB = 1'b1;
`else
    localparam bit IRQB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cs    [NI];
    logic              cyc   [NI];
    logic              stb   [NI];
    logic              we    [NI];
    logic [3:0]        sel   [NI];
    logic [31:0]       adr   [NI];
    logic [31:0]       dat   [NI];
    logic [NREG*32-1:0] regi [NI];
    logic [31:0]       isrc  [NI];
    logic              ack   [NI];
    logic              stall [NI];
    logic              irq   [NI];
    logic [31:0]       dato  [NI];
    logic [NREG*32-1:0] rego [NI];
    logic [NREG-1:0]   wrp   [NI];

    io_slave_regfile #(.NREG(NREG), .WAIT_STATES(1), .RO_MASK(16'h0004)) u0 (
        .clk_i(clk), .rst_i(rst_n), .cs_i(cs[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
        .ack_o(ack[0]), .stall_o(stall[0]), .we_i(we[0]), .sel_i(sel[0]), .adr_i(adr[0]),
        .dat_i(dat[0]), .dat_o(dato[0]), .reg_o(rego[0]), .reg_i(regi[0]),
        .wr_pulse_o(wrp[0]), .irq_src_i(isrc[0]), .irq_o(irq[0]));

    io_slave_regfile #(.NREG(NREG), .WAIT_STATES(0), .RO_MASK(16'h0004)) u1 (
        .clk_i(clk), .rst_i(rst_n), .cs_i(cs[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
        .ack_o(ack[1]), .stall_o(stall[1]), .we_i(we[1]), .sel_i(sel[1]), .adr_i(adr[1]),
        .dat_i(dat[1]), .dat_o(dato[1]), .reg_o(rego[1]), .reg_i(regi[1]),
        .wr_pulse_o(wrp[1]), .irq_src_i(isrc[1]), .irq_o(irq[1]));

    io_slave_regfile #(.NREG(NREG), .WAIT_STATES(4), .RO_MASK(16'h0004)) u2 (
        .clk_i(clk), .rst_i(rst_n), .cs_i(cs[2]), .cyc_i(cyc[2]), .stb_i(stb[2]),
        .ack_o(ack[2]), .stall_o(stall[2]), .we_i(we[2]), .sel_i(sel[2]), .adr_i(adr[2]),
        .dat_i(dat[2]), .dat_o(dato[2]), .reg_o(rego[2]), .reg_i(regi[2]),
        .wr_pulse_o(wrp[2]), .irq_src_i(isrc[2]), .irq_o(irq[2]));

    int checks = 0;
    int errors = 0;
    logic [31:0] mreg [NI][NREG];
    logic [NREG*32-1:0] romask;

    typedef struct packed {
        int          inst;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tab [11];

    function automatic int ws_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 4);
    endfunction

    function automatic bit is_ro(input int idx);
        return idx == 2;
    endfunction

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) r[8*k +: 8] = n[8*k +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic idle_bus(input int i);
        cs[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
    endtask

    task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit drop_cs, output logic [31:0] rd);
        int lat;
        int idx;
        bit got;
        idx = int'(a[5:2]);
        rd  = '0;
        cs[i] = 1'b1; cyc[i] = 1'b1; stb[i] = 1'b1;
        we[i] = w; adr[i] = a; dat[i] = d; sel[i] = s;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            if (drop_cs) cs[i] = 1'b0;
            if (ack[i]) got = 1'b1;
        end
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
            idle_bus(i);
            @(posedge clk); #1;
            return;
        end
        chk("latency", lat, ws_of(i) + 1);
        chk("wr_pulse", wrp[i], w ? (32'd1 << idx) : 32'd0);
        rd = dato[i];
        if (w && !is_ro(idx) && !(IRQB && idx == NREG - 1)) begin
            mreg[i][idx] = mmerge(mreg[i][idx], d, s);
        end
        if (!is_ro(idx) && !(IRQB && idx == NREG - 1)) begin
            chk("reg_o", rego[i][idx*32 +: 32], mreg[i][idx]);
        end
        @(posedge clk); #1;
        chk("ack_hold", ack[i], 1);
        chk("pulse_once", wrp[i], 0);
        chk("dat_hold", dato[i], rd);
        idle_bus(i);
        @(posedge clk); #1;
        chk("ack_drop", ack[i], 0);
        chk("dat_zero", dato[i], 0);
        chk("stall_idle", stall[i], 0);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_ack"}, ack[i], 0);
            chk({tag, "_stall"}, stall[i], 0);
            chk({tag, "_dat"}, dato[i], 0);
            chk({tag, "_wrp"}, wrp[i], 0);
            chk({tag, "_irq"}, irq[i], 0);
            chk({tag, "_regs_nonzero"}, 32'(|(rego[i] & ~romask)), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int i, idx;
        bit w, seen;
        logic [31:0] a, d, e;
        logic [3:0] s;

        romask = '0;
        romask[2*32 +: 32] = '1;
        for (int k = 0; k < NI; k++) begin
            idle_bus(k);
            sel[k] = '0; adr[k] = '0; dat[k] = '0; isrc[k] = '0;
            for (int n = 0; n < NREG; n++) begin
                regi[k][n*32 +: 32] = $urandom;
                mreg[k][n] = '0;
            end
        end
        regi[0][2*32 +: 32] = 32'hCAFEF00D;

        tab[0]  = '{inst:0, w:1, a:32'h0C, d:32'h12345678, s:4'hF, chk_rd:0, exp_rd:0};
        tab[1]  = '{inst:0, w:0, a:32'h0C, d:0, s:4'hF, chk_rd:1, exp_rd:32'h12345678};
        tab[2]  = '{inst:1, w:1, a:32'h14, d:32'hAABBCCDD, s:4'hF, chk_rd:0, exp_rd:0};
        tab[3]  = '{inst:1, w:1, a:32'h14, d:32'h11223344, s:4'h6, chk_rd:0, exp_rd:0};
        tab[4]  = '{inst:1, w:0, a:32'h14, d:0, s:4'hF, chk_rd:1, exp_rd:32'hAA2233DD};
        tab[5]  = '{inst:0, w:0, a:32'h08, d:0, s:4'hF, chk_rd:1, exp_rd:32'hCAFEF00D};
        tab[6]  = '{inst:0, w:1, a:32'h08, d:0, s:4'hF, chk_rd:0, exp_rd:0};
        tab[7]  = '{inst:0, w:0, a:32'h08, d:0, s:4'hF, chk_rd:1, exp_rd:32'hCAFEF00D};
        tab[8]  = '{inst:0, w:0, a:32'hFFFFFFCC, d:0, s:4'hF, chk_rd:1, exp_rd:32'h12345678};
        tab[9]  = '{inst:1, w:1, a:32'h14, d:32'hFFFFFFFF, s:4'h0, chk_rd:0, exp_rd:0};
        tab[10] = '{inst:1, w:0, a:32'h54, d:0, s:4'hF, chk_rd:1, exp_rd:32'hAA2233DD};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("after_reset");

        for (int t = 0; t < 11; t++) begin
            xfer(tab[t].inst, tab[t].w, tab[t].a, tab[t].d, tab[t].s, 1'b0, rd);
            if (tab[t].chk_rd) chk($sformatf("table_rd_%0d", t), rd, tab[t].exp_rd);
        end

        // cs dropped mid-cycle must not disturb the transfer
        xfer(2, 1'b1, 32'h18, 32'h600DCAFE, 4'hF, 1'b1, rd);
        xfer(2, 1'b0, 32'h18, 32'h0, 4'hF, 1'b1, rd);
        chk("cs_drop_rd", rd, 32'h600DCAFE);

        // abort during WAIT on the 4-wait-state instance
        cs[2] = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
        adr[2] = 32'h1C; dat[2] = 32'hDEADBEEF; sel[2] = 4'hF;
        @(posedge clk); #1;
        chk("abort_stall_wait", stall[2], 1);
        chk("abort_ack_wait", ack[2], 0);
        @(posedge clk); #1;
        chk("abort_ack_wait2", ack[2], 0);
        idle_bus(2);
        @(posedge clk); #1;
        chk("abort_stall_low", stall[2], 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (ack[2] || (wrp[2] != '0)) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_no_ack_no_pulse", seen, 0);
        chk("abort_no_write", rego[2][7*32 +: 32], mreg[2][7]);
        xfer(2, 1'b1, 32'h1C, 32'h0BADF00D, 4'hF, 1'b0, rd);
        xfer(2, 1'b0, 32'h1C, 32'h0, 4'hF, 1'b0, rd);
        chk("after_abort_rd", rd, 32'h0BADF00D);

        // randomized transfers against the model
        for (int r = 0; r < 150; r++) begin
            i = int'($urandom_range(0, NI - 1));
            w = 1'($urandom);
            a = $urandom;
            d = $urandom;
            s = 4'($urandom);
            idx = int'(a[5:2]);
            regi[i][2*32 +: 32] = $urandom;
            e = is_ro(idx) ? regi[i][idx*32 +: 32] : mreg[i][idx];
            xfer(i, w, a, d, s, 1'($urandom), rd);
            if (!w) chk($sformatf("rand_rd_%0d_i%0d_r%0d", r, i, idx), rd, e);
        end

`ifdef IO_SLAVE_IRQ_EN
        xfer(1, 1'b1, (NREG - 2) * 4, 32'h1, 4'hF, 1'b0, rd);
        isrc[1][0] = 1'b1;
        @(posedge clk); #1;
        isrc[1][0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("irq_pending_set", rego[1][(NREG-1)*32 +: 32], 32'h1);
        chk("irq_asserted", irq[1], 1);
        isrc[1][0] = 1'b1;
        xfer(1, 1'b1, (NREG - 1) * 4, 32'h1, 4'hF, 1'b0, rd);
        isrc[1][0] = 1'b0;
        chk("irq_set_wins", rego[1][(NREG-1)*32 +: 32], 32'h1);
        chk("irq_still_high", irq[1], 1);
        @(posedge clk); #1;
        xfer(1, 1'b1, (NREG - 1) * 4, 32'h1, 4'hF, 1'b0, rd);
        @(posedge clk); #1;
        chk("irq_pending_cleared", rego[1][(NREG-1)*32 +: 32], 32'h0);
        chk("irq_deasserted", irq[1], 0);
`endif

        // asynchronous reset while in ACK with stb held
        cs[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
        adr[0] = 32'h24; dat[0] = 32'h00000055; sel[0] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_ack", ack[0], 1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        idle_bus(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++)
            for (int n = 0; n < NREG; n++) mreg[k][n] = '0;
        xfer(0, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0, rd);
        chk("post_reset_rd", rd, 32'h0);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'hF, 1'b0, rd);
        chk("post_reset_rd3", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
